control_aritmetica: RTL and testbench

Sequencer for the shared `Aritmetica` multiplier datapath. On each `inicio` it shifts a new signed sample into a K-deep delay line, then, for K consecutive cycles, presents one sample/coefficient pair to the multiplier and accumulates the returned product. The accumulated sum is scaled by 2^-F, saturated to N bits and registered as `resultado`. This gives the control loop a K-term fixed-point weighted sum (FIR-style control law) using one multiplier instance.

---
 rtl/control_aritmetica.sv | 190 +++++++++++++++++++
 tb/tb_control_aritmetica.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_aritmetica.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : control_aritmetica
// Purpose  : Sequencer for the shared Aritmetica multiplier. Each accepted
//            inicio shifts a new signed sample into a K-deep delay line, then
//            for K cycles feeds one sample/coefficient pair to the external
//            multiplier and accumulates the product returned on Valores. The
//            sum is scaled by 2^-F, saturated to N bits and registered.
// Ports    : clk, reset        - rising-edge clock, async active-high reset
//            inicio, Entrada_G - start pulse and new sample
//            carga_coef, dir_coef, coef_dato - coefficient write port (idle)
//            Multip_G, Constantes_G - operands A/B to the multiplier
//            Valores           - signed 2N-bit product (same cycle)
//            resultado, listo  - registered result and one-cycle done pulse
//            ocupado           - high while a computation is in progress
// Revision : 1.0 - initial release
// ============================================================================
module control_aritmetica #(
  parameter int N  = 25,
  parameter int K  = 4,
  parameter int F  = 10,
  parameter int AW = $clog2(K)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic signed [N-1:0]   Entrada_G,
  input  logic                  carga_coef,
  input  logic [AW-1:0]         dir_coef,
  input  logic signed [N-1:0]   coef_dato,
  output logic signed [N-1:0]   Multip_G,
  output logic signed [N-1:0]   Constantes_G,
  input  logic signed [2*N-1:0] Valores,
  output logic signed [N-1:0]   resultado,
  output logic                  listo,
  output logic                  ocupado
);

  localparam int ACCW = 2*N + AW;

  // Saturation bounds, at accumulator width for comparison and at N bits
  // for the registered result.
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [N-1:0]    RES_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]    RES_MIN = {1'b1, {(N-1){1'b0}}};
  localparam logic [AW-1:0]          CNT_LAST = AW'(K-1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    MULT   = 2'd1,
    SATURA = 2'd2
  } estado_t;

  estado_t estado;
  estado_t estado_sig;

  logic signed [N-1:0]    x [K];
  logic signed [N-1:0]    c [K];
  logic signed [ACCW-1:0] acc;
  logic [AW-1:0]          cnt;

  logic                   acepta;
  logic                   escribe;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] escalado;
  logic signed [N-1:0]    saturado;

  // Start and coefficient writes are honoured only while idle.
  assign acepta   = (estado == REPOSO) && inicio;
  assign escribe  = (estado == REPOSO) && carga_coef;
  assign prod_ext = {{AW{Valores[2*N-1]}}, Valores};
  assign escalado = acc >>> F;

  always_comb begin
    saturado = escalado[N-1:0];
    if (escalado > SAT_MAX) begin
      saturado = RES_MAX;
    end else if (escalado < SAT_MIN) begin
      saturado = RES_MIN;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig   = estado;
    ocupado      = 1'b1;
    Multip_G     = '0;
    Constantes_G = '0;
    case (estado)
      REPOSO: begin
        ocupado = 1'b0;
        if (inicio) begin
          estado_sig = MULT;
        end
      end
      MULT: begin
        Multip_G     = x[cnt];
        Constantes_G = c[cnt];
        if (cnt == CNT_LAST) begin
          estado_sig = SATURA;
        end
      end
      SATURA: begin
        estado_sig = REPOSO;
      end
      default: begin
        estado_sig = REPOSO;
        ocupado    = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Delay line and coefficient bank. Addresses with no matching index
  // (dir_coef >= K for non-power-of-two K) simply write nothing.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < K; i++) begin : g_banco
    if (i == 0) begin : g_primero
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          x[i] <= '0;
        end else if (acepta) begin
          x[i] <= Entrada_G;
        end
      end
    end else begin : g_resto
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          x[i] <= '0;
        end else if (acepta) begin
          x[i] <= x[i-1];
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        c[i] <= '0;
      end else if (escribe && (dir_coef == AW'(i))) begin
        c[i] <= coef_dato;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator and term counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (acepta) begin
      acc <= '0;
      cnt <= '0;
    end else if (estado == MULT) begin
      acc <= acc + prod_ext;
      cnt <= cnt + AW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Result register and done pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resultado <= '0;
      listo     <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (estado == SATURA) begin
        resultado <= saturado;
        listo     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_aritmetica.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_control_aritmetica
// Purpose  : Self-checking bench for control_aritmetica. Supplies the
//            multiplier combinationally, keeps a transaction-level model of
//            the weighted sum and its schedule, and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_aritmetica;

  localparam int N  = 25;
  localparam int K  = 4;
  localparam int F  = 10;
  localparam int AW = 2;

  logic                  clk;
  logic                  reset;
  logic                  inicio;
  logic signed [N-1:0]   Entrada_G;
  logic                  carga_coef;
  logic [AW-1:0]         dir_coef;
  logic signed [N-1:0]   coef_dato;
  logic signed [N-1:0]   Multip_G;
  logic signed [N-1:0]   Constantes_G;
  logic signed [2*N-1:0] Valores;
  logic signed [N-1:0]   resultado;
  logic                  listo;
  logic                  ocupado;

  int errors = 0;
  int checks = 0;

  control_aritmetica #(.N(N), .K(K), .F(F), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .inicio       (inicio),
    .Entrada_G    (Entrada_G),
    .carga_coef   (carga_coef),
    .dir_coef     (dir_coef),
    .coef_dato    (coef_dato),
    .Multip_G     (Multip_G),
    .Constantes_G (Constantes_G),
    .Valores      (Valores),
    .resultado    (resultado),
    .listo        (listo),
    .ocupado      (ocupado)
  );

  // External multiplier: full-width signed product, low 2N bits.
  assign Valores = {{N{Multip_G[N-1]}}, Multip_G} * {{N{Constantes_G[N-1]}}, Constantes_G};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a transaction is the weighted sum of the K newest
  // samples, floor-divided by 2^F and clamped; it is scheduled as K+1 busy
  // cycles with operand pair j shown in busy cycle j, then a listo cycle.
  // --------------------------------------------------------------------------
  logic signed [N-1:0] mx [K];
  logic signed [N-1:0] mc [K];
  int                  phase;
  logic signed [N-1:0] pend;
  logic signed [N-1:0] res_e;
  logic                listo_e;

  function automatic logic signed [N-1:0] model_sum(input logic signed [N-1:0] s,
                                                     input logic wr,
                                                     input logic [AW-1:0] d,
                                                     input logic signed [N-1:0] cv);
    logic signed [N-1:0] xs [K];
    logic signed [N-1:0] cs [K];
    longint sum;
    longint q;
    longint lo;
    longint hi;
    for (int i = 0; i < K; i++) begin
      xs[i] = (i == 0) ? s : mx[i-1];
      cs[i] = mc[i];
    end
    if (wr) cs[d] = cv;
    sum = 0;
    for (int i = 0; i < K; i++) sum += longint'(xs[i]) * longint'(cs[i]);
    q  = sum >>> F;
    hi = (longint'(1) <<< (N-1)) - 1;
    lo = -(longint'(1) <<< (N-1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return N'(q);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) begin
        mx[i] <= '0;
        mc[i] <= '0;
      end
      phase   <= 0;
      pend    <= '0;
      res_e   <= '0;
      listo_e <= 1'b0;
    end else begin
      listo_e <= 1'b0;
      if (phase == 0) begin
        if (carga_coef) mc[dir_coef] <= coef_dato;
        if (inicio) begin
          mx[0] <= Entrada_G;
          for (int i = 1; i < K; i++) mx[i] <= mx[i-1];
          pend  <= model_sum(Entrada_G, carga_coef, dir_coef, coef_dato);
          phase <= 1;
        end
      end else if (phase == K + 1) begin
        res_e   <= pend;
        listo_e <= 1'b1;
        phase   <= 0;
      end else begin
        phase <= phase + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("ocupado", longint'(ocupado), longint'(phase != 0));
        check("listo", longint'(listo), longint'(listo_e));
        check("resultado", longint'(resultado), longint'(res_e));
        if (phase >= 1 && phase <= K) begin
          check("Multip_G", longint'(Multip_G), longint'(mx[phase-1]));
          check("Constantes_G", longint'(Constantes_G), longint'(mc[phase-1]));
        end else begin
          check("Multip_G_idle", longint'(Multip_G), 0);
          check("Constantes_G_idle", longint'(Constantes_G), 0);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after a rising edge)
  // --------------------------------------------------------------------------
  logic signed [N-1:0] opseq [K];

  task automatic set_coef(input int idx, input longint v);
    @(posedge clk); #2;
    carga_coef = 1'b1;
    dir_coef   = AW'(idx);
    coef_dato  = N'(v);
    @(posedge clk); #2;
    carga_coef = 1'b0;
  endtask

  task automatic start(input longint v);
    @(posedge clk); #2;
    inicio    = 1'b1;
    Entrada_G = N'(v);
    @(posedge clk); #2;
    inicio    = 1'b0;
  endtask

  // Call right after start(); returns edges from the inicio edge to listo
  // and records the operand A sequence of the first K cycles.
  task automatic wait_listo(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n <= K) opseq[n-1] = Multip_G;
      if (listo) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL listo_timeout: got none, expected pulse within 20 cycles");
    end
  endtask

  task automatic count_listo(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (listo) pulses++;
    end
  endtask

  int lat;
  int pulses;
  int unsigned tmp;

  initial begin
    reset      = 1'b1;
    inicio     = 1'b0;
    Entrada_G  = '0;
    carga_coef = 1'b0;
    dir_coef   = '0;
    coef_dato  = '0;
    #13;
    check("reset_resultado", longint'(resultado), 0);
    check("reset_ocupado", longint'(ocupado), 0);
    check("reset_listo", longint'(listo), 0);
    check("reset_Multip_G", longint'(Multip_G), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Unity weights
    for (int i = 0; i < K; i++) set_coef(i, 1024);
    start(100);
    wait_listo(lat);
    check("unity1_latency", lat, 5);
    check("unity1_result", longint'(resultado), 100);
    @(negedge clk);
    check("unity1_listo_width", longint'(listo), 0);
    start(200);
    wait_listo(lat);
    check("unity2_latency", lat, 5);
    check("unity2_result", longint'(resultado), 300);
    check("opseq0", longint'(opseq[0]), 200);
    check("opseq1", longint'(opseq[1]), 100);
    check("opseq2", longint'(opseq[2]), 0);
    check("opseq3", longint'(opseq[3]), 0);

    // Saturation
    set_coef(0, 64'sd8388608);
    for (int i = 1; i < K; i++) set_coef(i, 0);
    start(64'sd8388608);
    wait_listo(lat);
    check("sat_pos", longint'(resultado), 16777215);
    start(-64'sd8388608);
    wait_listo(lat);
    check("sat_neg", longint'(resultado), -16777216);

    // Negative truncation toward minus infinity
    set_coef(0, 512);
    start(-3);
    wait_listo(lat);
    check("trunc_neg", longint'(resultado), -2);

    // Busy protection: line is now [-3, -2^23, 2^23, 200]
    set_coef(0, 1024);
    set_coef(1, 1024);
    start(7);
    @(posedge clk); #2;
    inicio     = 1'b1;
    Entrada_G  = N'(999);
    carga_coef = 1'b1;
    dir_coef   = '0;
    coef_dato  = '0;
    @(posedge clk); #2;
    inicio     = 1'b0;
    carga_coef = 1'b0;
    count_listo(12, pulses);
    check("busy_pulses", pulses, 1);
    check("busy_result", longint'(resultado), 4);
    start(5);
    wait_listo(lat);
    check("busy_after", longint'(resultado), 12);

    // Reset in the middle of MULT
    for (int i = 2; i < K; i++) set_coef(i, 1024);
    start(9);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset_ocupado", longint'(ocupado), 0);
    check("midreset_listo", longint'(listo), 0);
    check("midreset_resultado", longint'(resultado), 0);
    check("midreset_Multip_G", longint'(Multip_G), 0);
    check("midreset_Constantes_G", longint'(Constantes_G), 0);
    @(posedge clk); #2 reset = 1'b0;
    count_listo(8, pulses);
    check("midreset_pulses", pulses, 0);
    check("midreset_hold", longint'(resultado), 0);
    set_coef(0, 1024);
    start(50);
    wait_listo(lat);
    check("after_reset", longint'(resultado), 50);

    // Randomized traffic, including requests while busy
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #2;
      inicio     = ($urandom_range(0, 3) == 0);
      tmp        = $urandom;
      Entrada_G  = ($urandom_range(0, 3) == 0) ? tmp[N-1:0] : N'(int'($urandom_range(0, 20000)) - 10000);
      carga_coef = ($urandom_range(0, 2) == 0);
      dir_coef   = AW'($urandom_range(0, K-1));
      tmp        = $urandom;
      coef_dato  = ($urandom_range(0, 4) == 0) ? tmp[N-1:0] : N'(int'($urandom_range(0, 4095)) - 2048);
    end
    @(posedge clk); #2;
    inicio     = 1'b0;
    carga_coef = 1'b0;
    repeat (K + 4) @(posedge clk);

    // Asynchronous reset between edges with a result held
    #3 reset = 1'b1;
    #1;
    check("async_reset_resultado", longint'(resultado), 0);
    check("async_reset_listo", longint'(listo), 0);
    check("async_reset_ocupado", longint'(ocupado), 0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
